// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a registered one-hot-opcode ALU.
// Each grant walks IDLE -> ISSUE -> CAPTURE -> DONE and returns a one-cycle done pulse.
module alu_arbiter #(
  parameter int unsigned OP_COUNT = 9
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        req0,
  input  logic        req1,
  input  logic [3:0]  op0,
  input  logic [3:0]  op1,
  input  logic [7:0]  a0,
  input  logic [7:0]  b0,
  input  logic [7:0]  a1,
  input  logic [7:0]  b1,
  output logic        done0,
  output logic        done1,
  output logic [7:0]  result,
  output logic        neg,
  output logic        err,
  output logic        busy,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [15:0] alu_op,
  input  logic [3:0]  alu_r1,
  input  logic [3:0]  alu_r2,
  input  logic        alu_neg
);

  typedef enum logic [1:0] {StIdle, StIssue, StCapture, StDone} state_e;

  localparam logic [4:0] OpLimit = 5'(OP_COUNT);
  localparam logic [3:0] OpSub   = 4'd1;

  state_e      state_q, state_d;
  logic        gnt_q;     // requester owning the operation in flight
  logic        last_q;    // requester granted most recently; resets to 1 so 0 wins first tie
  logic [3:0]  op_q;
  logic [7:0]  a_q, b_q;
  logic [7:0]  result_q;
  logic        neg_q, err_q;
  logic        any_req, win_sel, op_valid;

  assign any_req  = req0 | req1;
  assign win_sel  = (req0 && req1) ? ~last_q : req1;
  assign op_valid = {1'b0, op_q} < OpLimit;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (any_req) state_d = StIssue;
      StIssue:   state_d = StCapture;
      StCapture: state_d = StDone;
      StDone:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      gnt_q    <= 1'b0;
      last_q   <= 1'b1;
      op_q     <= 4'h0;
      a_q      <= 8'h00;
      b_q      <= 8'h00;
      result_q <= 8'h00;
      neg_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (state_q == StIdle && any_req) begin
        gnt_q  <= win_sel;
        last_q <= win_sel;
        op_q   <= win_sel ? op1 : op0;
        a_q    <= win_sel ? a1 : a0;
        b_q    <= win_sel ? b1 : b0;
      end
      // ALU output is valid one cycle after ISSUE, i.e. during CAPTURE.
      if (state_q == StCapture) begin
        result_q <= op_valid ? {alu_r2, alu_r1} : 8'h00;
        neg_q    <= op_valid && (op_q == OpSub) && alu_neg;
        err_q    <= ~op_valid;
      end
    end
  end

  always_comb begin
    busy   = (state_q != StIdle);
    done0  = (state_q == StDone) && !gnt_q;
    done1  = (state_q == StDone) && gnt_q;
    alu_op = 16'h0000;
    if (state_q == StIssue && op_valid) begin
      alu_op = 16'h0001 << op_q;
    end
    alu_a  = a_q;
    alu_b  = b_q;
    result = result_q;
    neg    = neg_q;
    err    = err_q;
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a registered behavioural ALU, a vector table of grants,
// and hand sequences for reset abort and back-to-back round-robin.
module tb_alu_arbiter;

  logic        Clk, Rst;
  logic        req0, req1;
  logic [3:0]  op0, op1;
  logic [7:0]  a0, b0, a1, b1;
  logic        done0, done1, neg, err, busy;
  logic [7:0]  result, alu_a, alu_b;
  logic [15:0] alu_op;
  logic [3:0]  alu_r1, alu_r2;
  logic        alu_neg;

  int checks = 0;
  int errors = 0;

  alu_arbiter #(.OP_COUNT(9)) dut (
    .Clk(Clk), .Rst(Rst), .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1), .done0(done0), .done1(done1),
    .result(result), .neg(neg), .err(err), .busy(busy), .alu_a(alu_a), .alu_b(alu_b),
    .alu_op(alu_op), .alu_r1(alu_r1), .alu_r2(alu_r2), .alu_neg(alu_neg)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Registered ALU; garbage when no opcode so forced-zero paths are visible.
  function automatic logic [8:0] alu_f(input logic [15:0] op, input logic [7:0] a,
                                       input logic [7:0] b);
    logic [7:0] r;
    r = 8'hA5;
    case (op)
      16'h0001: r = a + b;
      16'h0002: r = a - b;
      16'h0004: r = ~a;
      16'h0008: r = ~(a & b);
      16'h0010: r = ~(a | b);
      16'h0020: r = a & b;
      16'h0040: r = a | b;
      16'h0080: r = a ^ b;
      16'h0100: r = ~(a ^ b);
      default:  r = 8'hA5;
    endcase
    if (op == 16'h0002) return {(a < b), r};
    if (op == 16'h0000) return {1'b1, r};
    return {r[7], r};
  endfunction

  always @(posedge Clk) {alu_neg, alu_r2, alu_r1} <= alu_f(alu_op, alu_a, alu_b);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic       win;
    logic [7:0] res;
    logic       neg;
    logic       err;
  } exp_t;
  exp_t sb[$];

  always @(negedge Clk) begin
    if (done0 || done1) begin
      chk("done_overlap", 32'(done0 & done1), 32'd0);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=%0b%0b required=00 at %0t", done1, done0, $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_requester", 32'(done1), 32'(e.win));
        chk("sb_result", 32'(result), 32'(e.res));
        chk("sb_neg", 32'(neg), 32'(e.neg));
        chk("sb_err", 32'(err), 32'(e.err));
      end
    end
  end

  typedef struct {
    logic       rq0, rq1;
    logic [3:0] op0;
    logic [7:0] a0, b0;
    logic [3:0] op1;
    logic [7:0] a1, b1;
    logic       win;
    logic [7:0] res;
    logic       neg, err;
  } vec_t;

  function automatic vec_t mkv(input logic rq0, input logic rq1, input logic [3:0] o0,
                               input logic [7:0] x0, input logic [7:0] y0,
                               input logic [3:0] o1, input logic [7:0] x1,
                               input logic [7:0] y1, input logic win, input logic [7:0] res,
                               input logic n, input logic e);
    vec_t v;
    v.rq0 = rq0; v.rq1 = rq1; v.op0 = o0; v.a0 = x0; v.b0 = y0;
    v.op1 = o1; v.a1 = x1; v.b1 = y1; v.win = win; v.res = res; v.neg = n; v.err = e;
    return v;
  endfunction

  // Called just after a negedge with the DUT in IDLE; returns at a negedge in IDLE.
  task automatic run_txn(input vec_t v);
    exp_t        e;
    logic [3:0]  wop;
    logic [7:0]  wa, wb;
    logic [15:0] eop;
    req0 = v.rq0; req1 = v.rq1;
    op0 = v.op0; a0 = v.a0; b0 = v.b0;
    op1 = v.op1; a1 = v.a1; b1 = v.b1;
    wop = v.win ? v.op1 : v.op0;
    wa  = v.win ? v.a1 : v.a0;
    wb  = v.win ? v.b1 : v.b0;
    eop = (wop < 4'd9) ? (16'h0001 << wop) : 16'h0000;
    e.win = v.win; e.res = v.res; e.neg = v.neg; e.err = v.err;
    sb.push_back(e);
    @(negedge Clk);
    // ISSUE: withdraw requests and disturb operands; latched copy must be used.
    req0 = 1'b0; req1 = 1'b0;
    a0 = ~v.a0; b0 = ~v.b0; a1 = ~v.a1; b1 = ~v.b1; op0 = 4'h7; op1 = 4'h7;
    chk("issue_busy", 32'(busy), 32'd1);
    chk("issue_alu_op", 32'(alu_op), 32'(eop));
    chk("issue_alu_a", 32'(alu_a), 32'(wa));
    chk("issue_alu_b", 32'(alu_b), 32'(wb));
    @(negedge Clk);
    chk("capture_alu_op", 32'(alu_op), 32'd0);
    chk("capture_done", 32'({done1, done0}), 32'd0);
    chk("capture_alu_a", 32'(alu_a), 32'(wa));
    @(negedge Clk);
    chk("done_pulse", 32'({done1, done0}), v.win ? 32'd2 : 32'd1);
    chk("done_alu_op", 32'(alu_op), 32'd0);
    @(negedge Clk);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_done", 32'({done1, done0}), 32'd0);
    chk("hold_result", 32'(result), 32'(v.res));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'({done1, done0}), 32'd0);
    chk({tag, "_alu_op"}, 32'(alu_op), 32'd0);
    chk({tag, "_alu_ab"}, 32'({alu_a, alu_b}), 32'd0);
    chk({tag, "_result"}, 32'(result), 32'd0);
    chk({tag, "_flags"}, 32'({neg, err}), 32'd0);
  endtask

  vec_t vecs[14];

  initial begin
    int cnt;
    int t_prev;
    vecs[0]  = mkv(1'b1, 1'b0, 4'h0, 8'h12, 8'h34, 4'h0, 8'h00, 8'h00, 1'b0, 8'h46, 1'b0, 1'b0);
    vecs[1]  = mkv(1'b0, 1'b1, 4'h0, 8'h00, 8'h00, 4'h1, 8'h05, 8'h09, 1'b1, 8'hFC, 1'b1, 1'b0);
    vecs[2]  = mkv(1'b1, 1'b1, 4'h2, 8'h12, 8'h00, 4'h5, 8'hF0, 8'h3C, 1'b0, 8'hED, 1'b0, 1'b0);
    vecs[3]  = mkv(1'b1, 1'b1, 4'h6, 8'h50, 8'h0A, 4'h3, 8'hF0, 8'h3C, 1'b1, 8'hCF, 1'b0, 1'b0);
    vecs[4]  = mkv(1'b1, 1'b0, 4'h4, 8'hF0, 8'h0C, 4'h0, 8'h00, 8'h00, 1'b0, 8'h03, 1'b0, 1'b0);
    vecs[5]  = mkv(1'b0, 1'b1, 4'h0, 8'h00, 8'h00, 4'h5, 8'hF0, 8'h3C, 1'b1, 8'h30, 1'b0, 1'b0);
    vecs[6]  = mkv(1'b1, 1'b1, 4'h6, 8'h50, 8'h0A, 4'h7, 8'hFF, 8'h0F, 1'b0, 8'h5A, 1'b0, 1'b0);
    vecs[7]  = mkv(1'b0, 1'b1, 4'h0, 8'h00, 8'h00, 4'h7, 8'hFF, 8'h0F, 1'b1, 8'hF0, 1'b0, 1'b0);
    vecs[8]  = mkv(1'b1, 1'b0, 4'h8, 8'hAA, 8'h0F, 4'h0, 8'h00, 8'h00, 1'b0, 8'h5A, 1'b0, 1'b0);
    vecs[9]  = mkv(1'b1, 1'b0, 4'h1, 8'h09, 8'h05, 4'h0, 8'h00, 8'h00, 1'b0, 8'h04, 1'b0, 1'b0);
    vecs[10] = mkv(1'b0, 1'b1, 4'h0, 8'h00, 8'h00, 4'h9, 8'h12, 8'h34, 1'b1, 8'h00, 1'b0, 1'b1);
    vecs[11] = mkv(1'b0, 1'b1, 4'h0, 8'h00, 8'h00, 4'hF, 8'hFF, 8'hFF, 1'b1, 8'h00, 1'b0, 1'b1);
    vecs[12] = mkv(1'b1, 1'b0, 4'hB, 8'h12, 8'h34, 4'h0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
    // Tie right after an invalid-op grant to 0: pointer must have moved, so 1 wins.
    vecs[13] = mkv(1'b1, 1'b1, 4'h0, 8'h01, 8'h01, 4'h6, 8'h0F, 8'hF0, 1'b1, 8'hFF, 1'b0, 1'b0);

    Rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    op0 = 4'h0; op1 = 4'h0; a0 = 8'h00; b0 = 8'h00; a1 = 8'h00; b1 = 8'h00;
    #2;
    chk_reset_outputs("por");
    @(negedge Clk);
    Rst = 1'b0;

    for (int i = 0; i < 14; i++) run_txn(vecs[i]);

    // Both held from reset: grants 0,1,0,1 spaced 4 cycles; priority restored by reset.
    Rst = 1'b1;
    req0 = 1'b1; req1 = 1'b1;
    op0 = 4'h0; a0 = 8'h01; b0 = 8'h02;
    op1 = 4'h7; a1 = 8'hF0; b1 = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      exp_t e;
      e.win = i[0]; e.res = i[0] ? 8'h0F : 8'h03; e.neg = 1'b0; e.err = 1'b0;
      sb.push_back(e);
    end
    @(negedge Clk);
    Rst = 1'b0;
    cnt = 0;
    t_prev = 0;
    for (int cyc = 1; cyc <= 40 && cnt < 4; cyc++) begin
      @(negedge Clk);
      if (done0 || done1) begin
        if (cnt == 0) chk("rr_first_latency", 32'(cyc), 32'd3);
        else chk("rr_spacing", 32'(cyc - t_prev), 32'd4);
        t_prev = cyc;
        cnt++;
      end
    end
    chk("rr_done_count", 32'(cnt), 32'd4);
    req0 = 1'b0; req1 = 1'b0;
    @(negedge Clk);
    chk("rr_idle_busy", 32'(busy), 32'd0);

    // Reset while in CAPTURE: asynchronous clear, no done pulse.
    req1 = 1'b1; op1 = 4'h0; a1 = 8'h33; b1 = 8'h44;
    @(negedge Clk);
    req1 = 1'b0;
    @(negedge Clk);
    chk("abort_in_capture", 32'(busy), 32'd1);
    #2 Rst = 1'b1;
    #1 chk_reset_outputs("abort");
    @(negedge Clk);
    Rst = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    @(negedge Clk);
    chk("abort_no_busy", 32'(busy), 32'd0);
    run_txn(mkv(1'b0, 1'b1, 4'h0, 8'h00, 8'h00, 4'h0, 8'h05, 8'h09, 1'b1, 8'h0E, 1'b0, 1'b0));

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
